// File: rtl/seq_adder_if.sv
`default_nettype none
// ============================================================================
// Module : seq_adder_if -- start/busy/done handshake and operand/result bus
// Rev    : 1.0
// ============================================================================
interface seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_adder.sv
`default_nettype none
// ============================================================================
// Module : seq_adder -- digit-serial adder/subtractor, LSB digit first
// Rev    : 1.0
// ============================================================================
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_adder_if.slave bus
);
  localparam int            NSTEP     = WIDTH / DIGIT;
  localparam int            SW        = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [SW-1:0]    step_q, step_d;

  logic [DIGIT-1:0] s_dig;
  logic             c_nxt;

  // Operands shift right one digit per step; sum digits enter at the top.
  always_comb begin
    {c_nxt, s_dig} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, c_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    step_d  = step_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ^ bus.cin;
          step_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = c_nxt;
        sum_d  = (sum_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          step_d  = '0;
          cout_d  = c_nxt;
          // a^b^s at the MSB recovers the carry into bit WIDTH-1.
          ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ s_dig[DIGIT-1] ^ c_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_adder -- directed vectors, handshake corners, DIGIT sweep
// Rev    : 1.0
// ============================================================================
module tb_seq_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_sw_n;
  int   n_vec = 0;
  int   n_err = 0;

  seq_adder_if #(.WIDTH(16)) m();
  seq_adder #(.WIDTH(16), .DIGIT(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m));

  // Four sweep instances share one stimulus and are checked side by side.
  logic        sw_start, sw_cin, sw_sub;
  logic [15:0] sw_a, sw_b;
  logic [3:0]  sw_done, sw_busy, sw_cout, sw_ovf;
  logic [15:0] sw_sum [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int D = (gi == 3) ? 16 : (1 << gi);
    seq_adder_if #(.WIDTH(16)) sif();
    assign sif.start   = sw_start;
    assign sif.a       = sw_a;
    assign sif.b       = sw_b;
    assign sif.cin     = sw_cin;
    assign sif.sub     = sw_sub;
    assign sw_done[gi] = sif.done;
    assign sw_busy[gi] = sif.busy;
    assign sw_cout[gi] = sif.cout;
    assign sw_ovf[gi]  = sif.ovf;
    assign sw_sum[gi]  = sif.sum;
    seq_adder #(.WIDTH(16), .DIGIT(D)) u_sw (.clk(clk), .rst_n(rst_sw_n), .bus(sif));
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    m.a = v.a; m.b = v.b; m.cin = v.cin; m.sub = v.sub; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
  endtask

  // Entered 1 time unit after the accept edge; lat = edges until done.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (m.done !== 1'b1 && lat < 40) begin
      if (m.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, {31'b0, m.busy}, 32'd0);
    chk({tag, " done"}, {31'b0, m.done}, 32'd0);
    chk({tag, " sum"},  {16'b0, m.sum},  32'd0);
    chk({tag, " cout"}, {31'b0, m.cout}, 32'd0);
    chk({tag, " ovf"},  {31'b0, m.ovf},  32'd0);
  endtask

  function automatic int nstep_of(input int k);
    return (k == 3) ? 1 : (16 >> k);
  endfunction

  initial begin
    vec_t        tv [9];
    vec_t        v;
    int          lat, bc, dcnt;
    int          sw_lat [4];
    logic [16:0] full;
    logic [15:0] es;
    logic        ec, eo;

    tv[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tv[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[6] = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};
    tv[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tv[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    m.start = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;
    sw_start = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1; rst_sw_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start_op(tv[i]);
      wait_done(lat, bc);
      chk($sformatf("v%0d latency", i), lat, 32'd4);
      chk($sformatf("v%0d busy_cycles", i), bc, 32'd4);
      chk($sformatf("v%0d sum", i), {16'b0, m.sum}, {16'b0, tv[i].s});
      chk($sformatf("v%0d cout", i), {31'b0, m.cout}, {31'b0, tv[i].co});
      chk($sformatf("v%0d ovf", i), {31'b0, m.ovf}, {31'b0, tv[i].ov});
      @(posedge clk); #1;
      chk($sformatf("v%0d done_pulse", i), {31'b0, m.done}, 32'd0);
    end

    // Reset lands mid-RUN while cout/ovf still hold 1 from the last vector.
    v = '{16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    start_op(v);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle_zero("midreset");
    dcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m.done === 1'b1) dcnt++;
    end
    chk("midreset no_done", dcnt, 32'd0);
    v = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    start_op(v);
    wait_done(lat, bc);
    chk("post_reset latency", lat, 32'd4);
    chk("post_reset sum", {16'b0, m.sum}, 32'h0100);
    @(posedge clk); #1;

    // start held through RUN with scrambled operands.
    @(negedge clk);
    m.a = 16'h1111; m.b = 16'h2222; m.cin = 1'b0; m.sub = 1'b0; m.start = 1'b1;
    @(posedge clk); #1;
    m.a = 16'hFFFF; m.b = 16'h0F0F; m.cin = 1'b1; m.sub = 1'b1;
    wait_done(lat, bc);
    m.start = 1'b0;
    chk("held latency", lat, 32'd4);
    chk("held sum", {16'b0, m.sum}, 32'h3333);
    chk("held cout", {31'b0, m.cout}, 32'd0);
    chk("held ovf", {31'b0, m.ovf}, 32'd0);
    @(posedge clk); #1;
    chk("held single_done", {31'b0, m.done}, 32'd0);
    chk("held idle_busy", {31'b0, m.busy}, 32'd0);

    // Back-to-back: second start accepted in the DONE cycle.
    v = '{16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    start_op(v);
    wait_done(lat, bc);
    chk("b2b first sum", {16'b0, m.sum}, 32'h0300);
    m.a = 16'h00F0; m.b = 16'h0010; m.cin = 1'b0; m.sub = 1'b1; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    chk("b2b done_drops", {31'b0, m.done}, 32'd0);
    chk("b2b busy_now", {31'b0, m.busy}, 32'd1);
    wait_done(lat, bc);
    chk("b2b second latency", lat, 32'd4);
    chk("b2b second sum", {16'b0, m.sum}, 32'h00E0);
    chk("b2b second cout", {31'b0, m.cout}, 32'd1);
    chk("b2b second ovf", {31'b0, m.ovf}, 32'd0);
    @(posedge clk); #1;

    // DIGIT sweep against an arithmetic reference.
    for (int op = 0; op < 200; op++) begin
      @(negedge clk);
      sw_a = 16'($urandom); sw_b = 16'($urandom);
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      if (sw_sub) begin
        full = {1'b0, sw_a} - {1'b0, sw_b} - {16'b0, sw_cin};
        ec   = ~full[16];
        eo   = (sw_a[15] != sw_b[15]) && (full[15] != sw_a[15]);
      end else begin
        full = {1'b0, sw_a} + {1'b0, sw_b} + {16'b0, sw_cin};
        ec   = full[16];
        eo   = (sw_a[15] == sw_b[15]) && (full[15] != sw_a[15]);
      end
      es = full[15:0];
      sw_start = 1'b1;
      @(posedge clk); #1;
      sw_start = 1'b0;
      for (int k = 0; k < 4; k++) sw_lat[k] = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          if (sw_done[k] === 1'b1 && sw_lat[k] == 0) begin
            sw_lat[k] = cyc;
            chk($sformatf("sw op%0d k%0d sum", op, k), {16'b0, sw_sum[k]}, {16'b0, es});
            chk($sformatf("sw op%0d k%0d cout", op, k), {31'b0, sw_cout[k]}, {31'b0, ec});
            chk($sformatf("sw op%0d k%0d ovf", op, k), {31'b0, sw_ovf[k]}, {31'b0, eo});
          end
        end
      end
      for (int k = 0; k < 4; k++)
        chk($sformatf("sw op%0d k%0d latency", op, k), sw_lat[k], nstep_of(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_adder.md
Name: seq_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential generalisation of the single-bit full adder. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through a registered carry chain. A start/busy/done handshake frames each operation. It reports sum, carry-out and signed overflow, and serves datapaths that trade latency for area.

Parameters:
WIDTH, 16, operand and result width in bits
DIGIT, 4, bits added per clock; must divide WIDTH exactly (NSTEP = WIDTH/DIGIT); DIGIT = WIDTH gives a single-step add

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; latched when start is accepted
b  input  WIDTH  operand B; latched when start is accepted
cin  input  1  carry-in (add) or borrow-in (sub); latched when start is accepted
sub  input  1  0: sum = a+b+cin; 1: sum = a-b-cin; latched when start is accepted
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand, carry and step-count registers are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch operands and go to RUN.
  - RUN: one digit per edge. After the NSTEP-th digit, go to DONE.
  - DONE: start=1 -> latch operands and go to RUN (back-to-back). start=0 -> go to IDLE.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Digit step k (k = 0..NSTEP-1): {c_next, sum[k*DIGIT +: DIGIT]} = a[k*DIGIT +: DIGIT] + b_eff[k*DIGIT +: DIGIT] + c.
  - Width: DIGIT+1-bit add. The carry register holds c_next.
- Result flags:
  - cout = carry out of the final digit.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Both are computed in the last step; with DIGIT=1 the carry into the MSB is the carry register value.
- Latency: start is sampled at edge t.
  - busy=1 after edges t .. t+NSTEP-1.
  - After edge t+NSTEP: busy=0, done=1, state=DONE.
  - done is high for exactly one cycle unless a new start is accepted in DONE, in which case it drops at the next edge.
- Output visibility: sum, cout and ovf are visible as final values only while done=1 and thereafter. During RUN, sum holds partial digits and its value is unspecified.
- start while RUN: ignored. Latched operands are not disturbed and there is no restart.
- Input changes while RUN: changes on a, b, cin and sub have no effect.
- Reset mid-operation: abort immediately to reset values. No done pulse is issued.
- Simultaneous rst_n=0 and start=1: reset wins.

Test Plan:
- WIDTH=16, DIGIT=4, add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. done pulses exactly 4 edges after the start edge; busy is high for 4 cycles.
- Add boundaries: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0x0000+0x0000, cin=1 -> sum=0x0001.
- Subtract: sub=1, 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1. 0x0009-0x0003, cin=1 -> sum=0x0005, cout=1.
- Handshake:
  - start held during RUN with changed operands -> original result, single done.
  - start asserted in the DONE cycle -> second op begins with no idle cycle; second result correct after 4 more edges.
- Reset: rst_n=0 for one edge at RUN step 2 -> all outputs 0, no done. A following op 0x00FF+0x0001 -> 0x0100.
- Parameter sweep: DIGIT in {1, 2, 4, 16} with WIDTH=16, 200 random ops per DIGIT, compared against a reference model of a±b±cin. Latency = NSTEP edges for each DIGIT (16, 8, 4, 1).
